// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory-port arbiter:
// state encodings, byte-select width, default timeout and the latched bus command.
package mem_arbiter_pkg;

    localparam int SEL_W           = 4;
    localparam int DEFAULT_TIMEOUT = 255;

    localparam logic [SEL_W-1:0] SEL_ALL = '1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT_IF  = 2'd1,
        ST_GRANT_MEM = 2'd2
    } arb_state_e;

    typedef enum logic {
        SRC_IF  = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    typedef struct packed {
        logic             we;
        logic [SEL_W-1:0] sel;
        logic [31:0]      addr;
        logic [31:0]      wdata;
    } bus_cmd_t;

    // Data side normally wins; fetch wins only if data won last time and fetch is waiting.
    function automatic src_e pick_winner(input logic if_pend, input logic mem_pend,
                                         input src_e last);
        if (mem_pend && !(if_pend && last == SRC_MEM)) begin
            return SRC_MEM;
        end
        return SRC_IF;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store traffic onto a single memory port,
// with a per-transaction acknowledge timeout that aborts with zero data and bus_err_o.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             if_req_i,
    input  logic [31:0]      if_addr_i,
    output logic [31:0]      if_data_o,
    output logic             if_ack_o,
    output logic             stallreq_if_o,

    input  logic             mem_req_i,
    input  logic             mem_we_i,
    input  logic [SEL_W-1:0] mem_sel_i,
    input  logic [31:0]      mem_addr_i,
    input  logic [31:0]      mem_wdata_i,
    output logic [31:0]      mem_rdata_o,
    output logic             mem_ack_o,
    output logic             stallreq_mem_o,

    output logic             bus_req_o,
    output logic             bus_we_o,
    output logic [SEL_W-1:0] bus_sel_o,
    output logic [31:0]      bus_addr_o,
    output logic [31:0]      bus_wdata_o,
    input  logic [31:0]      bus_rdata_i,
    input  logic             bus_ack_i,
    output logic             bus_err_o
);

    localparam int            CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    arb_state_e    state_q, state_d;
    src_e          last_q, last_d;
    src_e          winner;
    bus_cmd_t      cmd_q, cmd_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          if_ack_q, if_ack_d;
    logic          mem_ack_q, mem_ack_d;
    logic          err_q, err_d;
    logic [31:0]   if_data_q, if_data_d;
    logic [31:0]   mem_data_q, mem_data_d;
    logic [31:0]   rsp_data;
    logic          if_pend, mem_pend;
    logic          timed_out;

    // A requester still holds its request during its own ack cycle; that is not a new request.
    assign if_pend  = if_req_i  & ~if_ack_q;
    assign mem_pend = mem_req_i & ~mem_ack_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d    = state_q;
        last_d     = last_q;
        cmd_d      = cmd_q;
        wait_d     = wait_q;
        if_ack_d   = 1'b0;
        mem_ack_d  = 1'b0;
        err_d      = 1'b0;
        if_data_d  = if_data_q;
        mem_data_d = mem_data_q;
        winner     = SRC_IF;
        rsp_data   = 32'h0;
        timed_out  = (wait_q == WAIT_LAST);

        unique case (state_q)
            ST_IDLE: begin
                if (if_pend || mem_pend) begin
                    winner = pick_winner(if_pend, mem_pend, last_q);
                    last_d = winner;
                    wait_d = '0;
                    if (winner == SRC_MEM) begin
                        cmd_d   = '{we: mem_we_i, sel: mem_sel_i, addr: mem_addr_i,
                                    wdata: mem_wdata_i};
                        state_d = ST_GRANT_MEM;
                    end else begin
                        cmd_d   = '{we: 1'b0, sel: SEL_ALL, addr: if_addr_i, wdata: 32'h0};
                        state_d = ST_GRANT_IF;
                    end
                end
            end
            ST_GRANT_IF, ST_GRANT_MEM: begin
                // A late ack wins over a timeout landing in the same cycle.
                if (bus_ack_i || timed_out) begin
                    rsp_data = bus_ack_i ? bus_rdata_i : 32'h0;
                    err_d    = ~bus_ack_i;
                    state_d  = ST_IDLE;
                    if (state_q == ST_GRANT_IF) begin
                        if_ack_d  = 1'b1;
                        if_data_d = rsp_data;
                    end else begin
                        mem_ack_d  = 1'b1;
                        mem_data_d = rsp_data;
                    end
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_q     <= SRC_IF;
            cmd_q      <= '0;
            wait_q     <= '0;
            if_ack_q   <= 1'b0;
            mem_ack_q  <= 1'b0;
            err_q      <= 1'b0;
            if_data_q  <= 32'h0;
            mem_data_q <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            last_q     <= last_d;
            cmd_q      <= cmd_d;
            wait_q     <= wait_d;
            if_ack_q   <= if_ack_d;
            mem_ack_q  <= mem_ack_d;
            err_q      <= err_d;
            if_data_q  <= if_data_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign bus_req_o   = (state_q != ST_IDLE);
    assign bus_we_o    = cmd_q.we;
    assign bus_sel_o   = cmd_q.sel;
    assign bus_addr_o  = cmd_q.addr;
    assign bus_wdata_o = cmd_q.wdata;
    assign bus_err_o   = err_q;

    assign if_ack_o    = if_ack_q;
    assign if_data_o   = if_data_q;
    assign mem_ack_o   = mem_ack_q;
    assign mem_rdata_o = mem_data_q;

    // Gated by reset so the stall lines also read 0 while reset is held.
    assign stallreq_if_o  = rst_n & if_pend;
    assign stallreq_mem_o = rst_n & mem_pend;

endmodule
